// File: rtl/uart_tx_frame.sv
// Parametrised UART transmitter: baud divider, 5..9 data bits, optional parity, 1/2 stop bits.
// Define UART_TX_FIFO_EN to place a FIFO_DEPTH-entry input FIFO in front of the frame FSM.
module uart_tx_frame #(
   parameter int CLK_DIV    = 868,
   parameter int DATA_BITS  = 8,
   parameter int PARITY     = 0,
   parameter int STOP_BITS  = 1,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [DATA_BITS-1:0] tx_data,
   input  logic                 tx_valid,
   output logic                 tx_ready,
   output logic                 txd,
   output logic                 tx_busy,
   output logic                 tx_done
);

   localparam int            BW        = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [BW-1:0] BAUD_LAST = BW'(CLK_DIV - 1);
   localparam logic [3:0]    DATA_LAST = 4'(DATA_BITS - 1);
   localparam logic [3:0]    STOP_LAST = 4'(STOP_BITS - 1);

   if (CLK_DIV < 2 || DATA_BITS < 5 || DATA_BITS > 9 || PARITY < 0 || PARITY > 2 ||
       STOP_BITS < 1 || STOP_BITS > 2 || FIFO_DEPTH < 2 ||
       (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_params
      $fatal(1, "uart_tx_frame: illegal parameter combination");
   end

   typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

   state_t                 state_q, state_d;
   logic [BW-1:0]          baud_q, baud_d;
   logic [3:0]             cnt_q, cnt_d;
   logic [DATA_BITS-1:0]   shift_q, shift_d;
   logic                   par_q, par_d;
   logic                   txd_d;
   logic                   bit_end, frame_end;
   logic                   start;
   logic [DATA_BITS-1:0]   start_data;

   assign bit_end   = (baud_q == BAUD_LAST);
   assign frame_end = (state_q == S_STOP) && bit_end && (cnt_q == STOP_LAST);
   assign tx_done   = frame_end;

`ifdef UART_TX_FIFO_EN
   localparam int AW = $clog2(FIFO_DEPTH);

   logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
   logic [AW:0]          wr_ptr, rd_ptr;
   logic                 fifo_empty, fifo_full, push;

   assign fifo_empty = (wr_ptr == rd_ptr);
   assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign push       = tx_valid && !fifo_full;
   assign tx_ready   = !fifo_full;
   assign start      = !fifo_empty && ((state_q == S_IDLE) || frame_end);
   assign start_data = mem[rd_ptr[AW-1:0]];
   assign tx_busy    = (state_q != S_IDLE) || !fifo_empty;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push)  wr_ptr <= wr_ptr + 1'b1;
         if (start) rd_ptr <= rd_ptr + 1'b1;
      end
   end

   // NOTE: storage is not reset; the pointers alone define which entries are valid.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr[AW-1:0]] <= tx_data;
   end
`else
   assign tx_ready   = (state_q == S_IDLE) || frame_end;
   assign start      = tx_valid && tx_ready;
   assign start_data = tx_data;
   assign tx_busy    = (state_q != S_IDLE);
`endif

   // NOTE: every variable gets a default first so no path through the case infers a latch.
   always_comb begin
      state_d = state_q;
      baud_d  = bit_end ? '0 : baud_q + BW'(1);
      cnt_d   = cnt_q;
      shift_d = shift_q;
      par_d   = par_q;
      case (state_q)
         S_IDLE: begin
            baud_d = '0;
            if (start) begin
               state_d = S_START;
               shift_d = start_data;
               par_d   = (PARITY == 1) ? ~(^start_data) : (^start_data);
            end
         end
         S_START: begin
            if (bit_end) begin
               state_d = S_DATA;
               cnt_d   = '0;
            end
         end
         S_DATA: begin
            if (bit_end) begin
               shift_d = shift_q >> 1;
               if (cnt_q == DATA_LAST) begin
                  state_d = (PARITY != 0) ? S_PARITY : S_STOP;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + 4'd1;
               end
            end
         end
         S_PARITY: begin
            if (bit_end) begin
               state_d = S_STOP;
               cnt_d   = '0;
            end
         end
         S_STOP: begin
            if (frame_end) begin
               cnt_d = '0;
               if (start) begin
                  state_d = S_START;
                  shift_d = start_data;
                  par_d   = (PARITY == 1) ? ~(^start_data) : (^start_data);
               end else begin
                  state_d = S_IDLE;
               end
            end else if (bit_end) begin
               cnt_d = cnt_q + 4'd1;
            end
         end
         default: state_d = S_IDLE;
      endcase

      // The line level is derived from the next state so txd leaves a flop, in step with state_q.
      case (state_d)
         S_START:  txd_d = 1'b0;
         S_DATA:   txd_d = shift_d[0];
         S_PARITY: txd_d = par_d;
         default:  txd_d = 1'b1;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments only, so all flops update together.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= S_IDLE;
         baud_q  <= '0;
         cnt_q   <= '0;
         shift_q <= '0;
         par_q   <= 1'b0;
         txd     <= 1'b1;
      end else begin
         state_q <= state_d;
         baud_q  <= baud_d;
         cnt_q   <= cnt_d;
         shift_q <= shift_d;
         par_q   <= par_d;
         txd     <= txd_d;
      end
   end

endmodule
